// File: rtl/wash_phase_scheduler.sv
// Eight-phase wash sequencer: latches a 26-bit program word and drives inlet/drain/motor per phase.
// Optional `WATER_LEVEL_EN adds fill-phase level sensing with a latched FAULT state.
module wash_phase_scheduler #(
    parameter int NPHASE      = 8,
    parameter int FAULT_DRAIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    input  logic [25:0] program_word,
    input  logic        water_full,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [2:0]  phase,
    output logic [3:0]  remain,
    output logic        inlet_valve,
    output logic        drain_valve,
    output logic        motor_on,
    output logic        motor_fast
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE, S_FAULT} state_t;

    localparam logic [2:0] LAST = 3'(NPHASE - 1);

    state_t      state, state_nx;
    logic [2:0]  ph_nx, ph_inc;
    logic [3:0]  rem_nx;
    logic [25:0] prog_q;
    logic        load;
    logic        fill_fault, fill_full;
    logic [3:0]  act_nx;   // {inlet, drain, motor, fast}

    function automatic logic [3:0] field(input logic [25:0] p, input logic [2:0] i);
        case (i)
            3'd0:    field = {1'b0, p[25:23]};
            3'd1:    field = p[22:19];
            3'd2:    field = {1'b0, p[18:16]};
            3'd3:    field = {1'b0, p[15:13]};
            3'd4:    field = {1'b0, p[12:10]};
            3'd5:    field = p[9:6];
            3'd6:    field = {1'b0, p[5:3]};
            default: field = {1'b0, p[2:0]};
        endcase
    endfunction

`ifdef WATER_LEVEL_EN
    logic is_fill;
    assign is_fill    = (phase == 3'd0) || (phase == 3'd3);
    assign fill_fault = is_fill && (remain == 4'd0) && !water_full;
    assign fill_full  = is_fill && water_full;
`else
    logic unused_water_full;
    assign unused_water_full = water_full;
    assign fill_fault        = 1'b0;
    assign fill_full         = 1'b0;
`endif

    assign ph_inc = phase + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            phase  <= '0;
            remain <= '0;
            prog_q <= '0;
        end else begin
            state  <= state_nx;
            phase  <= ph_nx;
            remain <= rem_nx;
            if (load) prog_q <= program_word;
        end
    end

    // A phase whose remain reaches 0 lingers one cycle before advancing, so a tick
    // on the 1->0 edge never also moves the phase.
    always_comb begin
        state_nx = state;
        ph_nx    = phase;
        rem_nx   = remain;
        load     = 1'b0;
        if (state == S_IDLE) begin
            if (start && !abort) begin
                state_nx = S_RUN;
                ph_nx    = 3'd0;
                rem_nx   = field(program_word, 3'd0);
                load     = 1'b1;
            end
        end else if (abort) begin
            state_nx = S_IDLE;
            ph_nx    = 3'd0;
            rem_nx   = 4'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (fill_fault)
                        state_nx = S_FAULT;
                    else if (pause)
                        state_nx = S_PAUSE;
                    else if (remain == 4'd0) begin
                        if (phase == LAST)
                            state_nx = S_DONE;
                        else begin
                            ph_nx  = ph_inc;
                            rem_nx = field(prog_q, ph_inc);
                        end
                    end else if (fill_full)
                        rem_nx = 4'd0;
                    else if (tick)
                        rem_nx = remain - 4'd1;
                end
                S_PAUSE: if (!pause) state_nx = S_RUN;
                S_DONE: begin
                    state_nx = S_IDLE;
                    ph_nx    = 3'd0;
                    rem_nx   = 4'd0;
                end
                default: ;
            endcase
        end
    end

    // Actuators follow the upcoming state so they register alongside phase/remain.
    always_comb begin
        act_nx = 4'b0000;
        if (state_nx == S_RUN && rem_nx != 4'd0) begin
            case (ph_nx)
                3'd0, 3'd3: act_nx = 4'b1000;
                3'd1, 3'd4: act_nx = 4'b0010;
                3'd2, 3'd6: act_nx = 4'b0100;
                default:    act_nx = 4'b0111;
            endcase
        end else if (state_nx == S_FAULT) begin
            act_nx = {1'b0, FAULT_DRAIN != 0, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            inlet_valve <= 1'b0;
            drain_valve <= 1'b0;
            motor_on    <= 1'b0;
            motor_fast  <= 1'b0;
        end else begin
            busy        <= (state_nx == S_RUN) || (state_nx == S_PAUSE);
            done        <= (state_nx == S_DONE);
            fault       <= (state_nx == S_FAULT);
            inlet_valve <= act_nx[3];
            drain_valve <= act_nx[2];
            motor_on    <= act_nx[1];
            motor_fast  <= act_nx[0];
        end
    end

endmodule
